fa_response_checker: RTL and testbench
======================================

// Module: fa_response_checker
// PURPOSE
//   Synthesizable response checker for the 1-bit full adder: the receiving end of the
//   full-adder stimulus path. Each valid cycle it samples the applied a/b/c vector and the
//   DUT's sum/carry, compares them against a built-in golden model and counts mismatches.
//   After NUM_SAMPLES samples it reports done and pass/fail. It sits beside the full adder
//   in benches and on-board self-test wrappers.
// PARAMETERS
//   NUM_SAMPLES  16  samples per run, >=1
//   CNT_W        8   width of err_count_out; the count saturates at 2**CNT_W-1
//   SCNT_W       $clog2(NUM_SAMPLES+1)  width of sample_count_out (derived localparam)
// PORTS
//   clk_in            in   1       single clock, rising edge
//   rst_n_in          in   1       asynchronous, active-low reset
//   start_in          in   1       begin a run; honoured only in IDLE or DONE
//   sample_valid_in   in   1       a/b/c and sum/carry are valid this cycle
//   a_in,b_in,c_in    in   1 each  stimulus vector applied to the DUT
//   sum_in,carry_in   in   1 each  DUT response for that vector
//   busy_out          out  1       high in RUN
//   done_out          out  1       high in DONE (level, not pulse)
//   pass_out          out  1       high in DONE when err_count_out==0; 0 elsewhere
//   err_count_out     out  CNT_W   number of mismatches this run (saturating)
//   sample_count_out  out  SCNT_W  number of samples taken this run
// BEHAVIOUR
//   Reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n_in).
//   - On reset: state=IDLE and every output is 0. Reset during RUN aborts the run.
//   Golden model: expected {carry,sum} = a_in + b_in + c_in, a 2-bit zero-extended add.
//   A mismatch is ({carry_in,sum_in} != expected). Any X/Z on a response counts as a mismatch
//   (use !== in simulation).
//   FSM states: IDLE, RUN, DONE. All transitions happen on the rising edge of clk_in.
//   - IDLE: start_in=1 -> RUN. Counters clear on the same edge. sample_valid_in is ignored.
//   - RUN: when sample_valid_in=1, sample_count+=1 and, on a mismatch, err_count+=1
//     (saturating). Both update on that edge, so the result is visible the next cycle.
//     start_in is ignored while in RUN.
//   - RUN -> DONE on the edge that takes the sample with sample_count==NUM_SAMPLES-1.
//     That final sample is included in the counts.
//   - DONE: counters hold. pass_out=(err_count==0). start_in=1 -> RUN with counters cleared.
//     sample_valid_in is ignored.
//   Boundaries:
//   - Start and valid in the same IDLE/DONE cycle: start only; that sample is not counted.
//   - NUM_SAMPLES=1: the first valid sample moves RUN directly to DONE.
//   - err_count stops at all-ones and never wraps.
// CONFIGURATION
//   Macro FA_CHK_CAPTURE_EN:
//   - Defined: adds outputs first_fail_vec_out[4:0]={a,b,c,carry,sum} and
//     first_fail_idx_out[SCNT_W-1:0]. Both latch on the first mismatch of a run and hold until
//     the next start or reset. Both are 0 if no mismatch has occurred.
//   - Undefined: these ports and their registers do not exist. All other behaviour is unchanged.
// STRUCTURE
//   Package fa_chk_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} fa_chk_state_t;
//   - the function fa_expected(a,b,c) returning logic [1:0].
//   Sub-module fa_ref_model: combinational golden full adder (a,b,c -> exp_sum, exp_carry).
//   It is instantiated once and reused by benches.
// TESTING
//   1 Reset mid-RUN after 5 samples -> all outputs 0 asynchronously; state IDLE.
//   2 NUM_SAMPLES=16, start, 16 valid cycles of all 8 vectors twice with a correct DUT
//     -> done_out=1, pass_out=1, err=0, sample_count=16.
//   3 Force sum_in inverted on samples 3 and 9 -> err=2, pass_out=0. With FA_CHK_CAPTURE_EN:
//     first_fail_idx_out=3 and first_fail_vec_out matches sample 3.
//   4 CNT_W=2, all 16 samples wrong -> err_count_out=3 (saturated), pass_out=0.
//   5 start_in together with valid in IDLE, then start during RUN -> the first sample is not
//     counted, the second start is ignored, and sample_count_out still ends at 16.
//   6 In DONE, pulse start -> counters read 0 next cycle; busy_out=1, done_out=0.

Source files
------------

// File: rtl/fa_chk_pkg.sv
// -----------------------------------------------------------------------------
// fa_chk_pkg
//   Shared types and helpers for the full-adder response checker.
//   - fa_chk_state_t : checker FSM encoding (IDLE, RUN, DONE)
//   - fa_expected()  : golden full-adder result, returned as {carry, sum}
//   Optional feature macro used by the checker top: FA_CHK_CAPTURE_EN.
// -----------------------------------------------------------------------------
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_chk_state_t;

  // The three 1-bit operands are zero-extended to 2 bits before adding, so
  // the result is {carry, sum} directly.
  function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// -----------------------------------------------------------------------------
// fa_ref_model
//   Combinational golden 1-bit full adder.
//   Ports:
//     a_in, b_in, c_in  in   operand bits and carry-in
//     exp_sum_out       out  expected sum
//     exp_carry_out     out  expected carry-out
// -----------------------------------------------------------------------------
module fa_ref_model
  import fa_chk_pkg::*;
(
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic exp_sum_out,
  output logic exp_carry_out
);

  logic [1:0] w_exp;

  assign w_exp         = fa_expected(a_in, b_in, c_in);
  assign exp_sum_out   = w_exp[0];
  assign exp_carry_out = w_exp[1];

endmodule

// File: rtl/fa_response_checker.sv
// -----------------------------------------------------------------------------
// fa_response_checker
//   Receiving end of the full-adder stimulus path. Each valid cycle in RUN it
//   compares the observed {carry, sum} against the golden model for the applied
//   a/b/c vector, counts samples and (saturating) mismatches, and after
//   NUM_SAMPLES samples parks in DONE reporting pass/fail.
//
//   Parameters:
//     NUM_SAMPLES  samples per run (>= 1)
//     CNT_W        width of err_count_out; saturates at all-ones
//     SCNT_W       derived width of sample_count_out
//
//   Ports:
//     clk_in            in   clock, rising edge
//     rst_n_in          in   asynchronous active-low reset
//     start_in          in   begin a run (honoured in IDLE or DONE only)
//     sample_valid_in   in   a/b/c and sum/carry are valid this cycle
//     a_in,b_in,c_in    in   vector applied to the adder under test
//     sum_in,carry_in   in   adder response for that vector
//     busy_out          out  high in RUN
//     done_out          out  high in DONE (level)
//     pass_out          out  high in DONE when no mismatches were seen
//     err_count_out     out  mismatches this run (saturating)
//     sample_count_out  out  samples taken this run
//     state_out         out  current FSM state (debug visibility)
//
//   Optional feature, macro FA_CHK_CAPTURE_EN:
//     first_fail_vec_out  out  {a,b,c,carry,sum} of the first mismatch of a run
//     first_fail_idx_out  out  sample index of that mismatch
//     Both hold until the next start or reset and read 0 if nothing failed.
//
//   Handshake: sample_valid_in is a pure qualifier with no back-pressure. The
//   checker accepts every cycle where sample_valid_in=1 while in RUN and
//   ignores it in IDLE and DONE; there is no ready signal.
// -----------------------------------------------------------------------------
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter  int NUM_SAMPLES = 16,
  parameter  int CNT_W       = 8,
  localparam int SCNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              sample_valid_in,
  input  logic              a_in,
  input  logic              b_in,
  input  logic              c_in,
  input  logic              sum_in,
  input  logic              carry_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              pass_out,
  output logic [CNT_W-1:0]  err_count_out,
  output logic [SCNT_W-1:0] sample_count_out,
  output fa_chk_state_t     state_out
`ifdef FA_CHK_CAPTURE_EN
  ,
  output logic [4:0]        first_fail_vec_out,
  output logic [SCNT_W-1:0] first_fail_idx_out
`endif
);

  fa_chk_state_t     r_state;
  logic [SCNT_W-1:0] r_scnt;
  logic [CNT_W-1:0]  r_ecnt;

  logic w_exp_sum;
  logic w_exp_carry;
  logic w_mismatch;
  logic w_take;
  logic w_last;
  logic w_restart;

  fa_ref_model u_ref (
    .a_in          (a_in),
    .b_in          (b_in),
    .c_in          (c_in),
    .exp_sum_out   (w_exp_sum),
    .exp_carry_out (w_exp_carry)
  );

  // Case inequality so an X/Z on the response is flagged as a mismatch in a
  // four-state simulator; it reduces to ordinary inequality in hardware.
  assign w_mismatch = ({carry_in, sum_in} !== {w_exp_carry, w_exp_sum});

  assign w_take    = (r_state == RUN) && sample_valid_in;
  assign w_last    = (r_scnt == SCNT_W'(NUM_SAMPLES - 1));
  assign w_restart = ((r_state == IDLE) || (r_state == DONE)) && start_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_ecnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_state <= RUN;
            r_scnt  <= '0;
            r_ecnt  <= '0;
          end
        end
        RUN: begin
          if (sample_valid_in) begin
            r_scnt <= r_scnt + SCNT_W'(1);
            if (w_mismatch && (r_ecnt != {CNT_W{1'b1}})) begin
              r_ecnt <= r_ecnt + CNT_W'(1);
            end
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (start_in) begin
            r_state <= RUN;
            r_scnt  <= '0;
            r_ecnt  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_out         = (r_state == RUN);
  assign done_out         = (r_state == DONE);
  assign pass_out         = (r_state == DONE) && (r_ecnt == '0);
  assign err_count_out    = r_ecnt;
  assign sample_count_out = r_scnt;
  assign state_out        = r_state;

`ifdef FA_CHK_CAPTURE_EN
  logic              r_ff_seen;
  logic [4:0]        r_ff_vec;
  logic [SCNT_W-1:0] r_ff_idx;

  // r_ff_seen keeps the capture to the first mismatch; it is cleared together
  // with the counters whenever a new run is started.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ff_seen <= 1'b0;
      r_ff_vec  <= '0;
      r_ff_idx  <= '0;
    end else if (w_restart) begin
      r_ff_seen <= 1'b0;
      r_ff_vec  <= '0;
      r_ff_idx  <= '0;
    end else if (w_take && w_mismatch && !r_ff_seen) begin
      r_ff_seen <= 1'b1;
      r_ff_vec  <= {a_in, b_in, c_in, carry_in, sum_in};
      r_ff_idx  <= r_scnt;
    end
  end

  assign first_fail_vec_out = r_ff_vec;
  assign first_fail_idx_out = r_ff_idx;
`endif

endmodule

// File: tb/tb_fa_response_checker.sv
// -----------------------------------------------------------------------------
// tb_fa_response_checker
//   Three checker instances share one stimulus stream:
//     u_dut  : NUM_SAMPLES=16, CNT_W=8
//     u_sat  : NUM_SAMPLES=16, CNT_W=2 (saturating error count)
//     u_one  : NUM_SAMPLES=1
//   Per-run expectations come from an independent XOR/majority adder model and
//   are queued when the run is driven, then popped when DONE is reached.
// -----------------------------------------------------------------------------
module tb_fa_response_checker;
  import fa_chk_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic start_in;
  logic sample_valid_in;
  logic a_in, b_in, c_in;
  logic sum_in, carry_in;

  logic          busy_m, done_m, pass_m;
  logic [7:0]    err_m;
  logic [4:0]    cnt_m;
  fa_chk_state_t st_m;

  logic          busy_s, done_s, pass_s;
  logic [1:0]    err_s;
  logic [4:0]    cnt_s;
  fa_chk_state_t st_s;

  logic          busy_o, done_o, pass_o;
  logic [7:0]    err_o;
  logic [0:0]    cnt_o;
  fa_chk_state_t st_o;

`ifdef FA_CHK_CAPTURE_EN
  logic [4:0] ffv_m, ffv_s, ffv_o;
  logic [4:0] ffi_m, ffi_s;
  logic [0:0] ffi_o;
`endif

  fa_response_checker #(.NUM_SAMPLES(16), .CNT_W(8)) u_dut (
    .clk_in (clk), .rst_n_in (rst_n), .start_in (start_in),
    .sample_valid_in (sample_valid_in),
    .a_in (a_in), .b_in (b_in), .c_in (c_in), .sum_in (sum_in), .carry_in (carry_in),
    .busy_out (busy_m), .done_out (done_m), .pass_out (pass_m),
    .err_count_out (err_m), .sample_count_out (cnt_m), .state_out (st_m)
`ifdef FA_CHK_CAPTURE_EN
    , .first_fail_vec_out (ffv_m), .first_fail_idx_out (ffi_m)
`endif
  );

  fa_response_checker #(.NUM_SAMPLES(16), .CNT_W(2)) u_sat (
    .clk_in (clk), .rst_n_in (rst_n), .start_in (start_in),
    .sample_valid_in (sample_valid_in),
    .a_in (a_in), .b_in (b_in), .c_in (c_in), .sum_in (sum_in), .carry_in (carry_in),
    .busy_out (busy_s), .done_out (done_s), .pass_out (pass_s),
    .err_count_out (err_s), .sample_count_out (cnt_s), .state_out (st_s)
`ifdef FA_CHK_CAPTURE_EN
    , .first_fail_vec_out (ffv_s), .first_fail_idx_out (ffi_s)
`endif
  );

  fa_response_checker #(.NUM_SAMPLES(1), .CNT_W(8)) u_one (
    .clk_in (clk), .rst_n_in (rst_n), .start_in (start_in),
    .sample_valid_in (sample_valid_in),
    .a_in (a_in), .b_in (b_in), .c_in (c_in), .sum_in (sum_in), .carry_in (carry_in),
    .busy_out (busy_o), .done_out (done_o), .pass_out (pass_o),
    .err_count_out (err_o), .sample_count_out (cnt_o), .state_out (st_o)
`ifdef FA_CHK_CAPTURE_EN
    , .first_fail_vec_out (ffv_o), .first_fail_idx_out (ffi_o)
`endif
  );

  // ---------------- scoreboard ----------------
  // exp_q entry: [15]=pass, [14:13]=saturated err (CNT_W=2), [12:5]=err, [4:0]=count
  logic [15:0] exp_q[$];
`ifdef FA_CHK_CAPTURE_EN
  // cap_q entry: [9:5]=first fail index, [4:0]=first fail vector
  logic [9:0]  cap_q[$];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive(input logic st, input logic vl, input logic [4:0] v);
    start_in        = st;
    sample_valid_in = vl;
    {a_in, b_in, c_in, carry_in, sum_in} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 5'd0);
  endtask

  // Independent golden vector for index i: {a,b,c,carry,sum}.
  function automatic logic [4:0] good_vec(input int i);
    logic [2:0] v;
    logic s, cy;
    v  = 3'(i);
    s  = v[2] ^ v[1] ^ v[0];
    cy = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return {v, cy, s};
  endfunction

  task automatic check_done();
    logic [15:0] e;
    for (int k = 0; k < 4 && done_m !== 1'b1; k++) drive_idle();
    check_eq("done_level", {31'd0, done_m}, 32'd1);
    check_eq("sb_depth", exp_q.size(), 32'd1);
    e = exp_q.pop_front();
    check_eq("count",     {27'd0, cnt_m},  {27'd0, e[4:0]});
    check_eq("err",       {24'd0, err_m},  {24'd0, e[12:5]});
    check_eq("pass",      {31'd0, pass_m}, {31'd0, e[15]});
    check_eq("busy_done", {31'd0, busy_m}, 32'd0);
    check_eq("state_done", {30'd0, st_m},  {30'd0, DONE});
    check_eq("sat_count", {27'd0, cnt_s},  {27'd0, e[4:0]});
    check_eq("sat_err",   {30'd0, err_s},  {30'd0, e[14:13]});
    check_eq("sat_pass",  {31'd0, pass_s}, {31'd0, e[15]});
    check_eq("sat_state", {30'd0, st_s},   {30'd0, DONE});
`ifdef FA_CHK_CAPTURE_EN
    begin
      logic [9:0] c;
      c = cap_q.pop_front();
      check_eq("ff_idx",     {27'd0, ffi_m}, {27'd0, c[9:5]});
      check_eq("ff_vec",     {27'd0, ffv_m}, {27'd0, c[4:0]});
      check_eq("sat_ff_idx", {27'd0, ffi_s}, {27'd0, c[9:5]});
      check_eq("sat_ff_vec", {27'd0, ffv_s}, {27'd0, c[4:0]});
    end
`endif
  endtask

  // Drives n valid samples (a run must already be started). Bits of inv_sum /
  // inv_carry corrupt that sample's response; x_idx puts X on sum; start_at
  // raises start_in together with that sample (must be ignored in RUN).
  task automatic run_samples(input int n, input logic [15:0] inv_sum,
                             input logic [15:0] inv_carry, input int x_idx,
                             input int start_at, input bit chk_one);
    logic [4:0] stim[16];
    int         err;
    logic [1:0] sat;
    bit         seen;
    logic [4:0] fvec;
    logic [4:0] fidx;
    err = 0; sat = 2'd0; seen = 1'b0; fvec = 5'd0; fidx = 5'd0;
    for (int i = 0; i < n; i++) begin
      stim[i] = good_vec(i);
      if (inv_sum[i])   stim[i][0] = ~stim[i][0];
      if (inv_carry[i]) stim[i][1] = ~stim[i][1];
      if (i == x_idx)   stim[i][0] = 1'bx;
      if (inv_sum[i] || inv_carry[i] || i == x_idx) begin
        err++;
        if (sat != 2'b11) sat = sat + 2'd1;
        if (!seen) begin
          seen = 1'b1;
          fvec = stim[i];
          fidx = 5'(i);
        end
      end
    end
    exp_q.push_back({(err == 0), sat, 8'(err), 5'(n)});
`ifdef FA_CHK_CAPTURE_EN
    cap_q.push_back({fidx, fvec});
`endif
    for (int i = 0; i < n; i++) begin
      drive((i == start_at), 1'b1, stim[i]);
      if (chk_one && i == 0) begin
        check_eq("one_done",  {31'd0, done_o}, 32'd1);
        check_eq("one_count", {31'd0, cnt_o},  32'd1);
        check_eq("one_pass",  {31'd0, pass_o}, {31'd0, (err == 0) || !(inv_sum[0] || inv_carry[0] || x_idx == 0)});
        check_eq("one_state", {30'd0, st_o},   {30'd0, DONE});
        check_eq("one_err",   {24'd0, err_o},  32'd0);
`ifdef FA_CHK_CAPTURE_EN
        check_eq("one_ff_vec", {27'd0, ffv_o}, 32'd0);
        check_eq("one_ff_idx", {31'd0, ffi_o}, 32'd0);
`endif
      end
      drive_idle_if_needed(i, start_at);
    end
    drive_idle();
    check_done();
  endtask

  // Spacer: after a sample that carried a stray start, insert one idle cycle
  // so a bubble in sample_valid_in is also exercised.
  task automatic drive_idle_if_needed(input int i, input int start_at);
    if (i == start_at) drive_idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start_in = 1'b0; sample_valid_in = 1'b0;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; sum_in = 1'b0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_eq("rst_busy",  {31'd0, busy_m}, 32'd0);
    check_eq("rst_done",  {31'd0, done_m}, 32'd0);
    check_eq("rst_pass",  {31'd0, pass_m}, 32'd0);
    check_eq("rst_err",   {24'd0, err_m},  32'd0);
    check_eq("rst_count", {27'd0, cnt_m},  32'd0);
    check_eq("rst_state", {30'd0, st_m},   {30'd0, IDLE});

    // Test 1: valid while IDLE is ignored, then reset mid-RUN after 5 samples
    drive(1'b0, 1'b1, good_vec(1));
    check_eq("idle_ignore", {27'd0, cnt_m}, 32'd0);
    drive(1'b1, 1'b0, 5'd0);
    check_eq("start_busy", {31'd0, busy_m}, 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, good_vec(i));
    check_eq("mid_count", {27'd0, cnt_m}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy",  {31'd0, busy_m}, 32'd0);
    check_eq("arst_count", {27'd0, cnt_m},  32'd0);
    check_eq("arst_err",   {24'd0, err_m},  32'd0);
    check_eq("arst_done",  {31'd0, done_m}, 32'd0);
    check_eq("arst_state", {30'd0, st_m},   {30'd0, IDLE});
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_idle();
    check_eq("post_rst_state", {30'd0, st_m}, {30'd0, IDLE});

    // Test 2: 16 correct samples (all 8 vectors twice); NUM_SAMPLES=1 instance
    // must finish on the very first sample.
    drive(1'b1, 1'b0, 5'd0);
    run_samples(16, 16'h0000, 16'h0000, -1, -1, 1'b1);

    // Test 3: sum inverted on samples 3 and 9
    drive(1'b1, 1'b0, 5'd0);
    run_samples(16, 16'h0208, 16'h0000, -1, -1, 1'b0);

    // Test 4: every sample wrong -> 16 errors, CNT_W=2 instance saturates at 3
    drive(1'b1, 1'b0, 5'd0);
    run_samples(16, 16'h0000, 16'hFFFF, -1, -1, 1'b0);

    // Test 6: start from DONE clears counters on the next cycle
    drive(1'b1, 1'b0, 5'd0);
    check_eq("restart_count", {27'd0, cnt_m},  32'd0);
    check_eq("restart_err",   {24'd0, err_m},  32'd0);
    check_eq("restart_busy",  {31'd0, busy_m}, 32'd1);
    check_eq("restart_done",  {31'd0, done_m}, 32'd0);
    check_eq("restart_pass",  {31'd0, pass_m}, 32'd0);
    check_eq("restart_sat",   {30'd0, err_s},  32'd0);
    // Continue the run with an X on the sum of sample 1 (expected sum there is 1)
    run_samples(16, 16'h0000, 16'h0000, 1, -1, 1'b0);

    // Test 5: start+valid together in IDLE (wrong response, not counted), then
    // a stray start during RUN; count must still end at 16 with no errors.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, good_vec(2) ^ 5'b00001);
    check_eq("sv_busy",  {31'd0, busy_m}, 32'd1);
    check_eq("sv_count", {27'd0, cnt_m},  32'd0);
    check_eq("sv_err",   {24'd0, err_m},  32'd0);
    run_samples(16, 16'h0000, 16'h0000, -1, 4, 1'b0);

    check_eq("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
